// File: rtl/fp_operand_unpack.sv
// Front stage of the FP add/sub datapath: unpacks two single-precision
// operands, applies the subtract sign flip and derives the adder metadata
// (magnitude order, saturated exponent shift, infinity/NaN flags).
module fp_operand_unpack #(
    parameter int unsigned SHIFT_SAT = 24
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        data_valid_i,
    output logic        data_ready_o,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        sub_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic        x_sign_o,
    output logic [7:0]  x_exp_o,
    output logic [22:0] x_frac_o,
    output logic        y_sign_o,
    output logic [7:0]  y_exp_o,
    output logic [22:0] y_frac_o,
    output logic        x_greater_o,
    output logic [7:0]  exp_shift_o,
    output logic        infinity_o,
    output logic        nan_o
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COMPARE = 2'd1;
    localparam logic [1:0] HOLD    = 2'd2;

    localparam logic [7:0] EXP_MAX = 8'hFF;

    logic [1:0]  state_q, state_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;          // b with effective (post-subtract) sign
    logic        data_ready_q, data_ready_d;
    logic        out_valid_q, out_valid_d;

    logic        x_sign_q, x_sign_d;
    logic [7:0]  x_exp_q, x_exp_d;
    logic [22:0] x_frac_q, x_frac_d;
    logic        y_sign_q, y_sign_d;
    logic [7:0]  y_exp_q, y_exp_d;
    logic [22:0] y_frac_q, y_frac_d;
    logic        x_greater_q, x_greater_d;
    logic [7:0]  exp_shift_q, exp_shift_d;
    logic        infinity_q, infinity_d;
    logic        nan_q, nan_d;

    logic [7:0]  x_exp_c, y_exp_c, exp_diff_c, exp_shift_c;
    logic [22:0] x_frac_c, y_frac_c;
    logic        x_nan_c, y_nan_c, x_inf_c, y_inf_c, nan_c, inf_c, x_greater_c;

    // Handshake sequencing and operand capture
    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (data_valid_i && data_ready_q) begin
                    a_d     = a_i;
                    b_d     = {b_i[31] ^ sub_i, b_i[30:0]};
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                state_d     = HOLD;
                out_valid_d = 1'b1;
            end
            HOLD: begin
                if (out_ready_i) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
            end
        endcase
        data_ready_d = (state_d == IDLE);
    end

    // Operand decomposition with denormal flush and special-value detection
    always_comb begin
        x_exp_c     = a_q[30:23];
        y_exp_c     = b_q[30:23];
        x_frac_c    = (x_exp_c == 8'd0) ? 23'd0 : a_q[22:0];
        y_frac_c    = (y_exp_c == 8'd0) ? 23'd0 : b_q[22:0];
        x_greater_c = {x_exp_c, x_frac_c} >= {y_exp_c, y_frac_c};
        exp_diff_c  = (x_exp_c >= y_exp_c) ? (x_exp_c - y_exp_c) : (y_exp_c - x_exp_c);
        exp_shift_c = (32'(exp_diff_c) >= SHIFT_SAT) ? 8'(SHIFT_SAT) : exp_diff_c;
        x_nan_c     = (x_exp_c == EXP_MAX) && (x_frac_c != 23'd0);
        y_nan_c     = (y_exp_c == EXP_MAX) && (y_frac_c != 23'd0);
        x_inf_c     = (x_exp_c == EXP_MAX) && (x_frac_c == 23'd0);
        y_inf_c     = (y_exp_c == EXP_MAX) && (y_frac_c == 23'd0);
        nan_c       = x_nan_c || y_nan_c || (x_inf_c && y_inf_c && (a_q[31] != b_q[31]));
        inf_c       = (x_inf_c || y_inf_c) && !nan_c;
    end

    // Result registers load only in COMPARE and hold otherwise
    always_comb begin
        x_sign_d    = x_sign_q;
        x_exp_d     = x_exp_q;
        x_frac_d    = x_frac_q;
        y_sign_d    = y_sign_q;
        y_exp_d     = y_exp_q;
        y_frac_d    = y_frac_q;
        x_greater_d = x_greater_q;
        exp_shift_d = exp_shift_q;
        infinity_d  = infinity_q;
        nan_d       = nan_q;
        if (state_q == COMPARE) begin
            x_sign_d    = a_q[31];
            x_exp_d     = x_exp_c;
            x_frac_d    = x_frac_c;
            y_sign_d    = b_q[31];
            y_exp_d     = y_exp_c;
            y_frac_d    = y_frac_c;
            x_greater_d = x_greater_c;
            exp_shift_d = exp_shift_c;
            infinity_d  = inf_c;
            nan_d       = nan_c;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            a_q          <= '0;
            b_q          <= '0;
            data_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            x_sign_q     <= 1'b0;
            x_exp_q      <= '0;
            x_frac_q     <= '0;
            y_sign_q     <= 1'b0;
            y_exp_q      <= '0;
            y_frac_q     <= '0;
            x_greater_q  <= 1'b0;
            exp_shift_q  <= '0;
            infinity_q   <= 1'b0;
            nan_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            a_q          <= a_d;
            b_q          <= b_d;
            data_ready_q <= data_ready_d;
            out_valid_q  <= out_valid_d;
            x_sign_q     <= x_sign_d;
            x_exp_q      <= x_exp_d;
            x_frac_q     <= x_frac_d;
            y_sign_q     <= y_sign_d;
            y_exp_q      <= y_exp_d;
            y_frac_q     <= y_frac_d;
            x_greater_q  <= x_greater_d;
            exp_shift_q  <= exp_shift_d;
            infinity_q   <= infinity_d;
            nan_q        <= nan_d;
        end
    end

    assign data_ready_o = data_ready_q;
    assign out_valid_o  = out_valid_q;
    assign x_sign_o     = x_sign_q;
    assign x_exp_o      = x_exp_q;
    assign x_frac_o     = x_frac_q;
    assign y_sign_o     = y_sign_q;
    assign y_exp_o      = y_exp_q;
    assign y_frac_o     = y_frac_q;
    assign x_greater_o  = x_greater_q;
    assign exp_shift_o  = exp_shift_q;
    assign infinity_o   = infinity_q;
    assign nan_o        = nan_q;

endmodule

// File: tb/tb_fp_operand_unpack.sv
// Directed bench for fp_operand_unpack with a queue scoreboard of expected results.
module tb_fp_operand_unpack;

    typedef struct packed {
        logic        xs;
        logic [7:0]  xe;
        logic [22:0] xf;
        logic        ys;
        logic [7:0]  ye;
        logic [22:0] yf;
        logic        xg;
        logic [7:0]  sh;
        logic        inf;
        logic        nan;
    } res_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        data_valid_i = 1'b0;
    logic        data_ready_o;
    logic [31:0] a_i = '0;
    logic [31:0] b_i = '0;
    logic        sub_i = 1'b0;
    logic        out_valid_o;
    logic        out_ready_i = 1'b0;
    logic        x_sign_o, y_sign_o, x_greater_o, infinity_o, nan_o;
    logic [7:0]  x_exp_o, y_exp_o, exp_shift_o;
    logic [22:0] x_frac_o, y_frac_o;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t sb[$];
    res_t got;
    res_t held;

    fp_operand_unpack #(.SHIFT_SAT(24)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o),
        .a_i(a_i), .b_i(b_i), .sub_i(sub_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .x_sign_o(x_sign_o), .x_exp_o(x_exp_o), .x_frac_o(x_frac_o),
        .y_sign_o(y_sign_o), .y_exp_o(y_exp_o), .y_frac_o(y_frac_o),
        .x_greater_o(x_greater_o), .exp_shift_o(exp_shift_o),
        .infinity_o(infinity_o), .nan_o(nan_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference result for one operand pair
    function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub);
        res_t r;
        int   d;
        logic xn, yn, xi, yi;
        r.xs = a[31];
        r.ys = b[31] ^ sub;
        r.xe = a[30:23];
        r.ye = b[30:23];
        r.xf = (r.xe == 0) ? 23'd0 : a[22:0];
        r.yf = (r.ye == 0) ? 23'd0 : b[22:0];
        if (r.xe != r.ye) r.xg = (r.xe > r.ye);
        else              r.xg = (r.xf >= r.yf);
        d = int'(r.xe) - int'(r.ye);
        if (d < 0) d = -d;
        r.sh = (d >= 24) ? 8'd24 : 8'(d);
        xn = (r.xe == 8'hFF) && (r.xf != 0);
        yn = (r.ye == 8'hFF) && (r.yf != 0);
        xi = (r.xe == 8'hFF) && (r.xf == 0);
        yi = (r.ye == 8'hFF) && (r.yf == 0);
        r.nan = xn | yn | (xi & yi & (r.xs != r.ys));
        r.inf = (xi | yi) & ~r.nan;
        return r;
    endfunction

    function automatic res_t observed();
        return '{x_sign_o, x_exp_o, x_frac_o, y_sign_o, y_exp_o, y_frac_o,
                 x_greater_o, exp_shift_o, infinity_o, nan_o};
    endfunction

    task automatic chk(input string tag, input logic [74:0] obs, input logic [74:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!data_ready_o && n < 10) begin
            tick();
            n++;
        end
        chk("ready_timeout", 75'(data_ready_o), 75'd1);
    endtask

    // Pop the scoreboard head and compare it with the presented result
    task automatic pop_cmp(input string tag, output res_t obs);
        res_t e;
        obs = observed();
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 75'd1, 75'd0);
        end else begin
            e = sb.pop_front();
            chk(tag, obs, e);
        end
    endtask

    // Full transaction: accept, COMPARE, HOLD, output handshake
    task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic sub, output res_t obs);
        wait_ready();
        a_i = a; b_i = b; sub_i = sub; data_valid_i = 1'b1;
        sb.push_back(model(a, b, sub));
        tick();
        data_valid_i = 1'b0;
        chk({tag, "_cmp_valid"}, 75'({out_valid_o, data_ready_o}), 75'b00);
        tick();
        chk({tag, "_hold_valid"}, 75'({out_valid_o, data_ready_o}), 75'b10);
        pop_cmp(tag, obs);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk({tag, "_idle"}, 75'({out_valid_o, data_ready_o}), 75'b01);
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("reset_hs", 75'({out_valid_o, data_ready_o}), 75'b00);
        chk("reset_out", observed(), 75'd0);
        rst_i = 1'b0;
        tick();
        chk("ready_after_reset", 75'({out_valid_o, data_ready_o}), 75'b01);

        // 1.0 + 2.0
        op("one_plus_two", 32'h3F800000, 32'h40000000, 1'b0, got);
        chk("one_plus_two_const", 75'({got.xe, got.ye, got.xg, got.sh, got.ys, got.inf, got.nan}),
            75'({8'd127, 8'd128, 1'b0, 8'd1, 1'b0, 1'b0, 1'b0}));
        // 3.0 - 1.0
        op("three_minus_one", 32'h40400000, 32'h3F800000, 1'b1, got);
        chk("three_minus_one_const", 75'({got.ys, got.xg, got.sh, got.xf}),
            75'({1'b1, 1'b1, 8'd1, 23'h400000}));
        // inf - inf and inf + inf
        op("inf_minus_inf", 32'h7F800000, 32'h7F800000, 1'b1, got);
        chk("inf_minus_inf_flags", 75'({got.nan, got.inf}), 75'b10);
        op("inf_plus_inf", 32'h7F800000, 32'h7F800000, 1'b0, got);
        chk("inf_plus_inf_flags", 75'({got.nan, got.inf}), 75'b01);
        op("qnan", 32'h7FC00000, 32'h3F800000, 1'b0, got);
        chk("qnan_flag", 75'(got.nan), 75'd1);
        op("inf_plus_one", 32'hFF800000, 32'h3F800000, 1'b1, got);
        // Shift saturation, denormal flush, ties, zeros
        op("shift_sat", 32'h4F800000, 32'h3F800000, 1'b0, got);
        chk("shift_sat_const", 75'(got.sh), 75'd24);
        op("exp_0_vs_255", 32'h00000000, 32'h7F800000, 1'b0, got);
        chk("exp_0_vs_255_const", 75'({got.sh, got.xg, got.inf}), 75'({8'd24, 1'b0, 1'b1}));
        op("denormal", 32'h00000001, 32'h3F800000, 1'b0, got);
        chk("denormal_const", 75'(got.xf), 75'd0);
        op("equal", 32'h3F800000, 32'h3F800000, 1'b1, got);
        chk("equal_const", 75'({got.xg, got.sh}), 75'({1'b1, 8'd0}));
        op("zeros", 32'h80000000, 32'h00000000, 1'b0, got);
        chk("zeros_const", 75'({got.xg, got.sh, got.inf, got.nan}), 75'({1'b1, 8'd0, 2'b00}));
        op("frac_order", 32'hC0A00001, 32'h40A00002, 1'b0, got);

        // Backpressure: held in HOLD while new operands wait upstream
        wait_ready();
        a_i = 32'h41200000; b_i = 32'hC0000000; sub_i = 1'b0; data_valid_i = 1'b1;
        sb.push_back(model(32'h41200000, 32'hC0000000, 1'b0));
        tick();
        a_i = 32'h3E800000; b_i = 32'h42C80000; sub_i = 1'b1;
        tick();
        pop_cmp("bp_first", held);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_stable", observed(), held);
            chk("bp_hs", 75'({out_valid_o, data_ready_o}), 75'b10);
        end
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;
        chk("bp_release", 75'({out_valid_o, data_ready_o}), 75'b01);
        sb.push_back(model(32'h3E800000, 32'h42C80000, 1'b1));
        tick();
        data_valid_i = 1'b0;
        chk("bp_second_cmp", 75'({out_valid_o, data_ready_o}), 75'b00);
        tick();
        chk("bp_second_hold", 75'(out_valid_o), 75'd1);
        pop_cmp("bp_second", got);
        out_ready_i = 1'b1;
        tick();
        out_ready_i = 1'b0;

        // Throughput with both handshakes held high: one accept every 3 cycles
        a_i = 32'h40490FDB; b_i = 32'h402DF854; sub_i = 1'b1;
        data_valid_i = 1'b1;
        out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) sb.push_back(model(32'h40490FDB, 32'h402DF854, 1'b1));
        for (int i = 0; i < 9; i++) begin
            chk("tput_ready", 75'(data_ready_o), 75'((i % 3) == 0));
            chk("tput_valid", 75'(out_valid_o), 75'((i % 3) == 2));
            if (out_valid_o) pop_cmp("tput_data", got);
            tick();
        end
        data_valid_i = 1'b0;
        out_ready_i = 1'b0;
        chk("tput_sb_drained", 75'(sb.size()), 75'd0);

        // Reset during COMPARE discards the operation
        tick();
        a_i = 32'h3F800000; b_i = 32'h7F800000; sub_i = 1'b0; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_mid_hs", 75'({out_valid_o, data_ready_o}), 75'b00);
        chk("rst_mid_out", observed(), 75'd0);
        tick();
        chk("rst_mid_ready", 75'({out_valid_o, data_ready_o}), 75'b01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_no_stale", 75'(out_valid_o), 75'd0);
        end

        // Reset during HOLD
        op("post_reset", 32'hC2F60000, 32'hC2F60000, 1'b1, got);
        wait_ready();
        a_i = 32'h3F800000; b_i = 32'h40000000; sub_i = 1'b0; data_valid_i = 1'b1;
        tick();
        data_valid_i = 1'b0;
        tick();
        chk("hold_before_rst", 75'(out_valid_o), 75'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        chk("rst_hold_out", observed(), 75'd0);
        chk("rst_hold_hs", 75'({out_valid_o, data_ready_o}), 75'b00);
        tick();
        chk("rst_hold_ready", 75'({out_valid_o, data_ready_o}), 75'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
